fft_result_display: RTL and testbench

Downstream stage of the FFT butterfly. Captures the four 8-bit butterfly outputs (Re Y, Im Y, Re Z, Im Z) as the controller strobes them onto the shared `result` bus, and holds them in a 4-entry result file. Drives a time-multiplexed 4-digit seven-segment display showing the entry chosen by `view_sel`. Sits between the butterfly top level and the board pin wrapper; the wrapper handles segment and anode polarity.

---
 rtl/fft_pkg.sv | 19 +
 rtl/hex_to_seg.sv | 31 +++
 rtl/fft_result_display.sv | 127 ++++++++++++
 tb/tb_fft_result_display.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly result path: result indices,
// display glyph constants and the result width.
package fft_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        RES_REY = 2'd0,
        RES_IMY = 2'd1,
        RES_REZ = 2'd2,
        RES_IMZ = 2'd3
    } res_idx_t;

    // Segment order is {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_MINUS   = 7'b1000000;
    localparam logic [6:0] SEG_INVALID = 7'b0001000;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder, segments {g,f,e,d,c,b,a}
// active high.
module hex_to_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        unique case (nibble)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/fft_result_display.sv
// Captures the four butterfly outputs into a result file and scans the
// selected entry onto a 4-digit display. FFT_SIGNED_DISPLAY_EN selects sign-magnitude view.
module fft_result_display
    import fft_pkg::res_idx_t, fft_pkg::RES_REY, fft_pkg::RES_IMY,
           fft_pkg::RES_REZ, fft_pkg::RES_IMZ, fft_pkg::SEG_BLANK,
           fft_pkg::SEG_MINUS, fft_pkg::SEG_INVALID;
#(
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] result,
    input  logic              display_ReY,
    input  logic              display_ImY,
    input  logic              display_ReZ,
    input  logic              display_ImZ,
    input  logic              clear,
    input  logic [1:0]        view_sel,
    output logic [6:0]        seg,
    output logic [3:0]        digit_en,
    output logic              all_valid,
    output logic              frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]     prescale;
    logic              wrap;
    logic [1:0]        idx;
    logic [1:0]        idx_next;
    logic [DATA_W-1:0] entry [4];
    logic [3:0]        valid;
    logic [3:0]        valid_next;
    logic              wr_en;
    res_idx_t          wr_idx;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic [DATA_W-1:0] mag;
    logic [6:0]        sign_seg;
    logic [3:0]        nibble;
    logic [6:0]        hex_seg;
    logic [6:0]        seg_next;

    // Strobe priority ReY > ImY > ReZ > ImZ; clear suppresses any write
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = RES_REY;
        if (display_ReY) begin
            wr_en  = 1'b1;
            wr_idx = RES_REY;
        end else if (display_ImY) begin
            wr_en  = 1'b1;
            wr_idx = RES_IMY;
        end else if (display_ReZ) begin
            wr_en  = 1'b1;
            wr_idx = RES_REZ;
        end else if (display_ImZ) begin
            wr_en  = 1'b1;
            wr_idx = RES_IMZ;
        end
        if (clear) wr_en = 1'b0;

        valid_next = valid;
        if (clear)      valid_next = '0;
        else if (wr_en) valid_next[wr_idx] = 1'b1;
    end

    assign wrap     = (prescale == PW'(SCAN_DIV - 1));
    assign idx_next = wrap ? idx + 2'd1 : idx;
    assign all_valid = &valid;

    assign sel_data  = entry[view_sel];
    assign sel_valid = valid[view_sel];

`ifdef FFT_SIGNED_DISPLAY_EN
    // 8'h80 negates to itself, which reads correctly as magnitude 80
    always_comb begin
        mag      = sel_data[DATA_W-1] ? (~sel_data + 1'b1) : sel_data;
        sign_seg = sel_data[DATA_W-1] ? SEG_MINUS : SEG_BLANK;
    end
`else
    assign mag      = sel_data;
    assign sign_seg = SEG_BLANK;
`endif

    assign nibble = idx_next[0] ? mag[DATA_W-1:4] : mag[3:0];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Decoded from the upcoming index so seg and digit_en switch together
    always_comb begin
        seg_next = SEG_BLANK;
        unique case (idx_next)
            2'd0, 2'd1: seg_next = hex_seg;
            2'd2:       seg_next = SEG_BLANK;
            2'd3:       seg_next = sign_seg;
            default:    seg_next = SEG_BLANK;
        endcase
        if (!sel_valid) seg_next = SEG_INVALID;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prescale   <= '0;
            idx        <= '0;
            valid      <= '0;
            frame_done <= 1'b0;
            seg        <= SEG_BLANK;
            digit_en   <= 4'b0001;
            for (int unsigned i = 0; i < 4; i++) entry[i] <= '0;
        end else begin
            prescale   <= wrap ? '0 : prescale + 1'b1;
            idx        <= idx_next;
            valid      <= valid_next;
            frame_done <= ~(&valid) & (&valid_next);
            seg        <= seg_next;
            digit_en   <= 4'b0001 << idx_next;
            if (wr_en) entry[wr_idx] <= result;
        end
    end

endmodule

// File: tb/tb_fft_result_display.sv
// Self-checking bench for fft_result_display with a fast scan (SCAN_DIV=4);
// expected digit contents are queued at capture time and popped as digits scan by.
module tb_fft_result_display;

    localparam int SD = 4;

    logic       Clock;
    logic       Reset;
    logic [7:0] result;
    logic       display_ReY, display_ImY, display_ReZ, display_ImZ;
    logic       clear;
    logic [1:0] view_sel;
    logic [6:0] seg;
    logic [3:0] digit_en;
    logic       all_valid;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] den;
        logic [6:0] seg;
    } exp_t;
    exp_t sb[$];

    localparam logic [6:0] S_BLANK = 7'b0000000;
    localparam logic [6:0] S_MINUS = 7'b1000000;
    localparam logic [6:0] S_INV   = 7'b0001000;

    fft_result_display #(
        .DATA_W   (8),
        .SCAN_DIV (SD)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .result      (result),
        .display_ReY (display_ReY),
        .display_ImY (display_ImY),
        .display_ReZ (display_ReZ),
        .display_ImZ (display_ImZ),
        .clear       (clear),
        .view_sel    (view_sel),
        .seg         (seg),
        .digit_en    (digit_en),
        .all_valid   (all_valid),
        .frame_done  (frame_done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push4(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3);
        sb.push_back('{4'b0001, d0});
        sb.push_back('{4'b0010, d1});
        sb.push_back('{4'b0100, d2});
        sb.push_back('{4'b1000, d3});
    endtask

    task automatic push_value(input logic [7:0] v, input bit ok);
        logic [7:0] m;
        logic [6:0] sgn;
        if (!ok) begin
            push4(S_INV, S_INV, S_INV, S_INV);
        end else begin
`ifdef FFT_SIGNED_DISPLAY_EN
            m   = v[7] ? 8'(0 - int'(v)) : v;
            sgn = v[7] ? S_MINUS : S_BLANK;
`else
            m   = v;
            sgn = S_BLANK;
`endif
            push4(font(m[3:0]), font(m[7:4]), S_BLANK, sgn);
        end
    endtask

    // Pops expectations in digit order as the scan reaches each digit
    task automatic drain(input string tag);
        int budget;
        budget = 20 * SD;
        @(posedge Clock);
        while (sb.size() > 0 && budget > 0) begin
            @(negedge Clock);
            budget--;
            if (digit_en === sb[0].den) begin
                checks++;
                if (seg !== sb[0].seg) begin
                    failures++;
                    $display("FAIL %s digit_en=%b: seg got %b expected %b",
                             tag, digit_en, seg, sb[0].seg);
                end
                void'(sb.pop_front());
            end
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout with %0d digits unseen", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [7:0] v);
        step();
        {display_ImZ, display_ReZ, display_ImY, display_ReY} = mask;
        result = v;
        step();
        {display_ImZ, display_ReZ, display_ImY, display_ReY} = 4'b0000;
    endtask

    task automatic do_clear();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        step();
        Reset = 1'b1;
        step();
        step();
        checks++;
        if (digit_en !== 4'b0001 || seg !== 7'b0000000) begin
            failures++;
            $display("FAIL reset_outputs: digit_en=%b seg=%b expected 0001/0000000", digit_en, seg);
        end
        chk1("reset_all_valid", all_valid, 1'b0);
        chk1("reset_frame_done", frame_done, 1'b0);
        Reset = 1'b0;
        step();
        checks++;
        if (seg !== S_INV || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_seg: seg=%b digit_en=%b expected %b/0001", seg, digit_en, S_INV);
        end
    endtask

    task automatic test_scan();
        logic [3:0] e;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            e = 4'b0001 << ((k / SD) % 4);
            checks++;
            if (digit_en !== e) begin
                failures++;
                $display("FAIL scan_edge%0d: digit_en got %b expected %b", k, digit_en, e);
            end
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL scan_midreset: digit_en got %b expected 0001", digit_en);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            e = (k == 4) ? 4'b0010 : 4'b0001;
            checks++;
            if (digit_en !== e) begin
                failures++;
                $display("FAIL scan_restart%0d: digit_en got %b expected %b", k, digit_en, e);
            end
        end
    endtask

    task automatic test_signed_capture();
        view_sel = 2'd0;
        strobe(4'b0001, 8'hF6);
`ifdef FFT_SIGNED_DISPLAY_EN
        push4(7'b1110111, 7'b0111111, S_BLANK, S_MINUS);
`else
        push4(7'b1111101, 7'b1110001, S_BLANK, S_BLANK);
`endif
        drain("capture_F6");
    endtask

    task automatic test_edge_value();
        strobe(4'b0001, 8'h80);
`ifdef FFT_SIGNED_DISPLAY_EN
        push4(7'b0111111, 7'b1111111, S_BLANK, S_MINUS);
`else
        push4(7'b0111111, 7'b1111111, S_BLANK, S_BLANK);
`endif
        drain("edge_80");
        strobe(4'b0010, 8'h3C);
        view_sel = 2'd1;
        push_value(8'h3C, 1'b1);
        drain("positive_3C");
    endtask

    task automatic test_hold_priority();
        do_clear();
        view_sel = 2'd2;
        step();
        display_ReZ = 1'b1;
        result = 8'h11;
        step();
        result = 8'h5A;
        step();
        display_ReZ = 1'b0;
        push_value(8'h5A, 1'b1);
        drain("hold_last_wins");
        do_clear();
        strobe(4'b1110, 8'h42);
        view_sel = 2'd1;
        push_value(8'h42, 1'b1);
        drain("prio_imy_written");
        view_sel = 2'd2;
        push_value(8'h00, 1'b0);
        drain("prio_rez_skipped");
        strobe(4'b1100, 8'h0B);
        push_value(8'h0B, 1'b1);
        drain("prio_rez_written");
        view_sel = 2'd3;
        push_value(8'h00, 1'b0);
        drain("prio_imz_skipped");
        chk1("prio_all_valid", all_valid, 1'b0);
    endtask

    task automatic test_frame();
        do_clear();
        for (int c = 1; c <= 47; c++) begin
            display_ReY = (c == 10) || (c == 43);
            display_ImY = (c == 20);
            display_ReZ = (c == 30);
            display_ImZ = (c == 40);
            result      = 8'(c);
            @(negedge Clock);
            chk1($sformatf("frame_done_c%0d", c), frame_done, c == 41);
            chk1($sformatf("all_valid_c%0d", c), all_valid, c >= 41);
            step();
        end
        {display_ImZ, display_ReZ, display_ImY, display_ReY} = 4'b0000;
        view_sel = 2'd0;
        push_value(8'd43, 1'b1);
        drain("frame_rey_rewrite");
        view_sel = 2'd3;
        push_value(8'd40, 1'b1);
        drain("frame_imz");
    endtask

    task automatic test_clear_conflict();
        step();
        clear = 1'b1;
        display_ImZ = 1'b1;
        result = 8'h99;
        view_sel = 2'd3;
        step();
        clear = 1'b0;
        display_ImZ = 1'b0;
        @(negedge Clock);
        chk1("clear_all_valid", all_valid, 1'b0);
        push_value(8'h00, 1'b0);
        drain("clear_imz_invalid");
        strobe(4'b1000, 8'h77);
        push_value(8'h77, 1'b1);
        drain("after_clear_imz");
        view_sel = 2'd0;
        push_value(8'h00, 1'b0);
        drain("after_clear_rey_invalid");
    endtask

    task automatic test_reset_discard();
        strobe(4'b0001, 8'h21);
        strobe(4'b0010, 8'h22);
        strobe(4'b0100, 8'h23);
        view_sel = 2'd1;
        step();
        Reset = 1'b1;
        clear = 1'b0;
        display_ImZ = 1'b1;
        step();
        Reset = 1'b0;
        display_ImZ = 1'b0;
        chk1("reset_discard_all_valid", all_valid, 1'b0);
        push_value(8'h00, 1'b0);
        drain("reset_discard_imy");
        view_sel = 2'd3;
        push_value(8'h00, 1'b0);
        drain("reset_over_strobe_imz");
    endtask

    initial begin
        Reset = 1'b1;
        result = '0;
        {display_ImZ, display_ReZ, display_ImY, display_ReY} = 4'b0000;
        clear = 1'b0;
        view_sel = 2'd0;
        test_reset();
        test_scan();
        test_signed_capture();
        test_edge_value();
        test_hold_priority();
        test_frame();
        test_clear_conflict();
        test_reset_discard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
